// File: rtl/uart_mmio_if.sv
// Load/store bus between the core's data-memory side and the UART window.
interface uart_mmio_if;
    logic        sel;
    logic [3:0]  addr;
    logic [1:0]  mem_write;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, addr, mem_write, rd_en, wdata, input rdata);
    modport slave  (input sel, addr, mem_write, rd_en, wdata, output rdata);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serializer, synchronised RX
// deserializer feeding an RX FIFO, and a status register with sticky error flags.

module uart_mmio_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;

    // Pointer update; the extra MSB separates full from empty on wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push) begin
                wptr_r <= wptr_r + 1'b1;
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop) begin
                rptr_r <= rptr_r + 1'b1;
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

    // Entry storage; callers only push when there is room
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

    assign head  = mem_r[rptr_r[AW-1:0]];
    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
endmodule

module uart_mmio #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_mmio_if.slave bus,
    output logic       tx,
    input  logic       rx
);
    localparam int             CW        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    // Bus decode
    logic        acc_ok_s;
    logic        tx_wr_s;
    logic        rx_rd_s;
    logic        st_rd_s;
    logic [31:0] rdata_s;
    logic [31:0] status_s;
    logic        unused_s;

    // TX side
    tx_state_t     tx_state_r;
    tx_state_t     tx_state_nxt_s;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]    tx_idx_r;
    logic [7:0]    tx_shift_r;
    logic          tx_r;
    logic          tx_nxt_s;
    logic          tx_pop_s;
    logic          tx_bit_end_s;
    logic          tx_push_s;
    logic [7:0]    tx_head_s;
    logic          tx_full_s;
    logic          tx_empty_s;

    // RX side
    logic [1:0]    rx_sync_r;
    logic          rx_s;
    rx_state_t     rx_state_r;
    rx_state_t     rx_state_nxt_s;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_idx_r;
    logic [7:0]    rx_shift_r;
    logic          rx_bit_end_s;
    logic          rx_half_end_s;
    logic          rx_push_req_s;
    logic          rx_ferr_set_s;
    logic          rx_push_s;
    logic          rx_ovr_set_s;
    logic [7:0]    rx_head_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic          overrun_r;
    logic          ferr_r;

    assign unused_s = ^bus.wdata[31:8];

    // Access strobes for the three registers
    always_comb begin
        acc_ok_s = bus.sel && (bus.addr[1:0] == 2'b00);
        tx_wr_s  = acc_ok_s && (bus.addr[3:2] == 2'b00) && (bus.mem_write != 2'b00);
        rx_rd_s  = acc_ok_s && (bus.addr[3:2] == 2'b01) && bus.rd_en && !rx_empty_s;
        st_rd_s  = acc_ok_s && (bus.addr[3:2] == 2'b10) && bus.rd_en;
    end

    assign status_s = {25'h000_0000, ferr_r, overrun_r, (tx_state_r != TX_IDLE),
                       rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};

    // Combinational read mux
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (acc_ok_s) begin
            case (bus.addr[3:2])
                2'b01: begin
                    if (rx_empty_s) begin
                        rdata_s = 32'hFFFF_FFFF;
                    end else begin
                        rdata_s = {24'h00_0000, rx_head_s};
                    end
                end
                2'b10:   rdata_s = status_s;
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bus.rdata = rdata_s;

    // A full FIFO drops the write even if the serializer pops this cycle
    assign tx_push_s = tx_wr_s && !tx_full_s;

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .wdata (bus.wdata[7:0]),
        .head  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    assign tx_bit_end_s = (tx_cnt_r == BIT_LAST);

    // TX state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_r <= TX_IDLE;
        end else begin
            tx_state_r <= tx_state_nxt_s;
        end
    end

    // TX next-state logic
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) tx_state_nxt_s = TX_START;
                else             tx_state_nxt_s = TX_IDLE;
            end
            TX_START: begin
                if (tx_bit_end_s) tx_state_nxt_s = TX_DATA;
                else              tx_state_nxt_s = TX_START;
            end
            TX_DATA: begin
                if (tx_bit_end_s && (tx_idx_r == 3'd7)) tx_state_nxt_s = TX_STOP;
                else                                   tx_state_nxt_s = TX_DATA;
            end
            TX_STOP: begin
                if (!tx_bit_end_s)   tx_state_nxt_s = TX_STOP;
                else if (tx_empty_s) tx_state_nxt_s = TX_IDLE;
                else                 tx_state_nxt_s = TX_START;
            end
            default: tx_state_nxt_s = TX_IDLE;
        endcase
    end

    // TX outputs: FIFO pop and next line level (line itself is registered)
    always_comb begin
        tx_pop_s = 1'b0;
        tx_nxt_s = tx_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s = 1'b1;
                    tx_nxt_s = 1'b0;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end_s) tx_nxt_s = tx_shift_r[0];
                else              tx_nxt_s = 1'b0;
            end
            TX_DATA: begin
                if (!tx_bit_end_s)          tx_nxt_s = tx_r;
                else if (tx_idx_r == 3'd7)  tx_nxt_s = 1'b1;
                else                        tx_nxt_s = tx_shift_r[1];
            end
            TX_STOP: begin
                if (tx_bit_end_s && !tx_empty_s) begin
                    tx_pop_s = 1'b1;
                    tx_nxt_s = 1'b0;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            default: begin
                tx_pop_s = 1'b0;
                tx_nxt_s = 1'b1;
            end
        endcase
    end

    // TX datapath: baud counter, bit index, shift register, line
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_r       <= 1'b1;
            tx_cnt_r   <= '0;
            tx_idx_r   <= 3'd0;
            tx_shift_r <= 8'h00;
        end else begin
            tx_r <= tx_nxt_s;
            if ((tx_state_r == TX_IDLE) || tx_bit_end_s) tx_cnt_r <= '0;
            else                                          tx_cnt_r <= tx_cnt_r + 1'b1;
            if (tx_pop_s) begin
                tx_shift_r <= tx_head_s;
            end else if ((tx_state_r == TX_DATA) && tx_bit_end_s) begin
                tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            end else begin
                tx_shift_r <= tx_shift_r;
            end
            if (tx_state_r != TX_DATA)  tx_idx_r <= 3'd0;
            else if (tx_bit_end_s)      tx_idx_r <= tx_idx_r + 3'd1;
            else                        tx_idx_r <= tx_idx_r;
        end
    end

    assign tx = tx_r;

    // RX input synchroniser, idles high
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
        end
    end

    assign rx_s          = rx_sync_r[1];
    assign rx_bit_end_s  = (rx_cnt_r == BIT_LAST);
    assign rx_half_end_s = (rx_cnt_r == HALF_LAST);

    // RX state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_state_nxt_s;
        end
    end

    // RX next-state logic; a bad stop bit waits for the line to return high
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_s) rx_state_nxt_s = RX_START;
                else       rx_state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (!rx_half_end_s) rx_state_nxt_s = RX_START;
                else if (rx_s)      rx_state_nxt_s = RX_IDLE;
                else                rx_state_nxt_s = RX_DATA;
            end
            RX_DATA: begin
                if (rx_bit_end_s && (rx_idx_r == 3'd7)) rx_state_nxt_s = RX_STOP;
                else                                   rx_state_nxt_s = RX_DATA;
            end
            RX_STOP: begin
                if (!rx_bit_end_s) rx_state_nxt_s = RX_STOP;
                else if (rx_s)     rx_state_nxt_s = RX_IDLE;
                else               rx_state_nxt_s = RX_BREAK;
            end
            RX_BREAK: begin
                if (rx_s) rx_state_nxt_s = RX_IDLE;
                else      rx_state_nxt_s = RX_BREAK;
            end
            default: rx_state_nxt_s = RX_IDLE;
        endcase
    end

    // RX outputs: byte delivery and framing error at the stop sample
    always_comb begin
        rx_push_req_s = 1'b0;
        rx_ferr_set_s = 1'b0;
        if ((rx_state_r == RX_STOP) && rx_bit_end_s) begin
            rx_push_req_s = rx_s;
            rx_ferr_set_s = !rx_s;
        end else begin
            rx_push_req_s = 1'b0;
            rx_ferr_set_s = 1'b0;
        end
    end

    // RX datapath: baud counter reloads at each sample, so no drift builds up
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_cnt_r   <= '0;
            rx_idx_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_START: begin
                    if (rx_half_end_s) rx_cnt_r <= '0;
                    else               rx_cnt_r <= rx_cnt_r + 1'b1;
                end
                RX_DATA, RX_STOP: begin
                    if (rx_bit_end_s) rx_cnt_r <= '0;
                    else              rx_cnt_r <= rx_cnt_r + 1'b1;
                end
                default: rx_cnt_r <= '0;
            endcase
            if ((rx_state_r == RX_DATA) && rx_bit_end_s) begin
                rx_shift_r <= {rx_s, rx_shift_r[7:1]};
                rx_idx_r   <= rx_idx_r + 3'd1;
            end else if (rx_state_r != RX_DATA) begin
                rx_shift_r <= rx_shift_r;
                rx_idx_r   <= 3'd0;
            end else begin
                rx_shift_r <= rx_shift_r;
                rx_idx_r   <= rx_idx_r;
            end
        end
    end

    // A firmware pop in the same cycle frees the slot for the incoming byte
    assign rx_push_s    = rx_push_req_s && (!rx_full_s || rx_rd_s);
    assign rx_ovr_set_s = rx_push_req_s && rx_full_s && !rx_rd_s;

    uart_mmio_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push_s),
        .pop   (rx_rd_s),
        .wdata (rx_shift_r),
        .head  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // Sticky error flags; a new error beats a same-cycle STATUS clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun_r <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            if (rx_ovr_set_s)  overrun_r <= 1'b1;
            else if (st_rd_s)  overrun_r <= 1'b0;
            else               overrun_r <= overrun_r;
            if (rx_ferr_set_s) ferr_r <= 1'b1;
            else if (st_rd_s)  ferr_r <= 1'b0;
            else               ferr_r <= ferr_r;
        end
    end
endmodule
